rf_wb_buffer: RTL and testbench
===============================

RF_WB_BUFFER -- requirements
Module: rf_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered writeback entries (power of two, 2..16).
REQ-002 SHALL have clk_i  input  1  clock; one clock, all state updates on rising edge.
REQ-003 SHALL have rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have wb_valid_i  input  1  the producer offers a writeback.
REQ-005 SHALL have wb_ready_o  output  1  the buffer accepts a writeback this cycle.
REQ-006 SHALL have wb_addr_i  input  5  destination register index.
REQ-007 SHALL have wb_data_i  input  32  destination register value.
REQ-008 SHALL have drain_en_i  input  1  the register file write port is available this cycle.
REQ-009 SHALL have rf_we_o  output  1  write enable to the register file.
REQ-010 SHALL have rf_waddr_o  output  5  write address to the register file.
REQ-011 SHALL have rf_wdata_o  output  32  write data to the register file.
REQ-012 SHALL have rd_addr1_i, rd_addr2_i  input  5 each  register file read addresses to check for pending writes.
REQ-013 SHALL have fwd_hit1_o, fwd_hit2_o  output  1 each  a pending write targets the matching read address.
REQ-014 SHALL have fwd_data1_o, fwd_data2_o  output  32 each  the forwarded value; 0 when there is no hit.
REQ-015 SHALL have count_o  output  $clog2(DEPTH)+1  occupancy.

Function
REQ-016 SHALL accept a writeback (handshake) in any cycle where wb_valid_i=1 and wb_ready_o=1.
REQ-017 SHALL drive wb_ready_o = !full && !rst_i; there is no pass-through when full, even if a pop occurs in the same cycle.
REQ-018 SHALL accept, but never enqueue, a handshake with wb_addr_i=0; count_o is unchanged.
REQ-019 SHALL enqueue an accepted nonzero-address entry at the tail; it becomes visible at the head or to forwarding from the next cycle.
REQ-020 SHALL drive rf_we_o = !empty && drain_en_i, with rf_waddr_o and rf_wdata_o taken from the head entry (combinational from registered state).
REQ-021 SHALL pop the head at the clock edge of every cycle where rf_we_o=1; the drain rate is one entry per cycle.
REQ-022 SHALL hold rf_waddr_o and rf_wdata_o at 0 when empty.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order; this holds at both count=DEPTH-1 and count=1.
REQ-024 SHALL wrap head and tail pointers modulo DEPTH without loss or duplication.
REQ-025 SHALL compute forwarding combinationally over all valid stored entries; the youngest matching entry wins; the entry being written this cycle still counts as a hit.
REQ-026 SHALL never report a forwarding hit for read address 0.
REQ-027 SHALL compute forwarding independently per read port; both ports may hit the same entry.
REQ-028 SHALL keep count_o equal to the number of valid entries at all times, never exceeding DEPTH.

Reset
REQ-029 SHALL, while rst_i=1 at an edge, clear count, head, tail and all valid bits; entry data need not be cleared.
REQ-030 SHALL, in the cycle after reset, present count_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fwd_hit*_o=0, fwd_data*_o=0 and wb_ready_o=1.
REQ-031 SHALL discard any buffered entries and any same-cycle handshake when reset is asserted mid-operation; no rf_we_o pulse results from them.

Verification
REQ-032 SHALL pass this scenario: reset, then push (5,0xAAAA0005) with drain_en_i=1 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xAAAA0005; following cycle count_o=0.
REQ-033 SHALL pass this scenario: drain_en_i=0, push 4 entries to x1..x4 -> count_o=4, wb_ready_o=0; a 5th valid is not accepted; drain_en_i=1 -> writes x1,x2,x3,x4 on 4 consecutive cycles.
REQ-034 SHALL pass this scenario: drain_en_i=0, push (7,0x11) then (7,0x22), rd_addr1_i=7 -> fwd_hit1_o=1, fwd_data1_o=0x22; rd_addr2_i=8 -> fwd_hit2_o=0, fwd_data2_o=0.
REQ-035 SHALL pass this scenario: push (0,0xDEAD) -> accepted, count_o stays 0, rf_we_o stays 0; rd_addr1_i=0 -> fwd_hit1_o=0.
REQ-036 SHALL pass this scenario: continuous push every cycle with drain_en_i=1 for 10 cycles to x1..x10 -> count_o stays 1 and writes occur in order with no loss across pointer wrap.
REQ-037 SHALL pass this scenario: 3 entries buffered, assert rst_i for one cycle with wb_valid_i=1 -> next cycle count_o=0, rf_we_o=0, and none of the entries is ever written.

Source files
------------

// File: rtl/rf_wb_buffer.sv
// rf_wb_buffer
// Small FIFO that sits between the writeback stage and a register file whose
// single write port is not always available. Writebacks are queued in order,
// drained one per cycle while drain_en_i is high, and every queued value can
// be forwarded to two read ports so readers never see stale register data.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   wb_valid_i / wb_ready_o      writeback handshake (accepted when both high)
//   wb_addr_i, wb_data_i         writeback destination index and value
//   drain_en_i                   register file write port free this cycle
//   rf_we_o, rf_waddr_o,
//   rf_wdata_o                   register file write, taken from the head entry
//   rd_addr1_i, rd_addr2_i       read addresses checked against pending writes
//   fwd_hit1_o/2_o,
//   fwd_data1_o/2_o              forwarding result per read port (data 0 on miss)
//   count_o                      number of buffered entries
module rf_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_valid_i,
  output logic                       wb_ready_o,
  input  logic [4:0]                 wb_addr_i,
  input  logic [31:0]                wb_data_i,
  input  logic                       drain_en_i,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_waddr_o,
  output logic [31:0]                rf_wdata_o,
  input  logic [4:0]                 rd_addr1_i,
  input  logic [4:0]                 rd_addr2_i,
  output logic                       fwd_hit1_o,
  output logic                       fwd_hit2_o,
  output logic [31:0]                fwd_data1_o,
  output logic [31:0]                fwd_data2_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [PW-1:0]    idx;

  assign empty      = (count == {CW{1'b0}});
  assign full       = (count == CW'(DEPTH));
  // No pass-through when full: a same-cycle pop does not open a slot.
  assign wb_ready_o = !full && !rst_i;
  // Writes to x0 complete the handshake but are dropped here.
  assign push       = wb_valid_i && wb_ready_o && (wb_addr_i != 5'd0);
  assign rf_we_o    = !empty && drain_en_i && !rst_i;
  assign pop        = rf_we_o;
  assign count_o    = count;

  // Head entry drives the register file write port; zeros when empty.
  always_comb begin
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (empty) begin
      rf_waddr_o = 5'd0;
      rf_wdata_o = 32'd0;
    end else begin
      rf_waddr_o = addr_mem[head];
      rf_wdata_o = data_mem[head];
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overwrites older ones.
  // The head entry being drained this cycle is still stored and therefore still hits.
  always_comb begin
    fwd_hit1_o  = 1'b0;
    fwd_hit2_o  = 1'b0;
    fwd_data1_o = 32'd0;
    fwd_data2_o = 32'd0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (addr_mem[idx] == rd_addr1_i) && (rd_addr1_i != 5'd0)) begin
        fwd_hit1_o  = 1'b1;
        fwd_data1_o = data_mem[idx];
      end else begin
        fwd_hit1_o  = fwd_hit1_o;
        fwd_data1_o = fwd_data1_o;
      end
      if (valid[idx] && (addr_mem[idx] == rd_addr2_i) && (rd_addr2_i != 5'd0)) begin
        fwd_hit2_o  = 1'b1;
        fwd_data2_o = data_mem[idx];
      end else begin
        fwd_hit2_o  = fwd_hit2_o;
        fwd_data2_o = fwd_data2_o;
      end
    end
  end

  // Entry storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[tail] <= wb_addr_i;
      data_mem[tail] <= wb_data_i;
    end
  end

  // Pointers, valid bits and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        tail        <= tail + PW'(1);
        valid[tail] <= 1'b1;
      end
      if (pop) begin
        head        <= head + PW'(1);
        valid[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_buffer.sv
// Directed testbench for rf_wb_buffer (DEPTH=4). A table of per-cycle input
// vectors with hand-computed expected outputs is applied one vector per
// cycle; outputs are checked after the inputs settle, before the next edge.
// A hand-written drain sequence then checks order and back-to-back writes.
module tb_rf_wb_buffer;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        drain_en;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  rf_wb_buffer #(.DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_valid_i (wb_valid),
    .wb_ready_o (wb_ready),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .drain_en_i (drain_en),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata),
    .rd_addr1_i (rd_addr1),
    .rd_addr2_i (rd_addr2),
    .fwd_hit1_o (fwd_hit1),
    .fwd_hit2_o (fwd_hit2),
    .fwd_data1_o(fwd_data1),
    .fwd_data2_o(fwd_data2),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        dr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                     input logic dr, input logic [4:0] r1, input logic [4:0] r2,
                     input logic rdy, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [2:0] cnt, input logic h1, input logic [31:0] d1,
                     input logic h2, input logic [31:0] d2);
    vec_t t;
    t.rst = r;  t.v = v;  t.a = a;  t.d = d;  t.dr = dr;  t.r1 = r1;  t.r2 = r2;
    t.e_rdy = rdy;  t.e_we = we;  t.e_wa = wa;  t.e_wd = wd;  t.e_cnt = cnt;
    t.e_h1 = h1;  t.e_d1 = d1;  t.e_h2 = h2;  t.e_d2 = d2;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic build_table();
    // Post-reset idle state
    add(1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    // Single push then immediate drain; push not yet visible in its own cycle
    add(1'b0,1'b1,5'd5,32'hAAAA0005,1'b1,5'd5,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd5,5'd5, 1'b1,1'b1,5'd5,32'hAAAA0005,3'd1, 1'b1,32'hAAAA0005,1'b1,32'hAAAA0005);
    add(1'b0,1'b0,5'd0,32'd0,1'b0,5'd5,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    // Fill to full with drain disabled
    for (int i = 1; i <= 4; i++) begin
      add(1'b0,1'b1,5'(i),32'h100 + 32'(i),1'b0,5'd0,5'd0,
          1'b1,1'b0,(i == 1) ? 5'd0 : 5'd1,(i == 1) ? 32'd0 : 32'h101,3'(i - 1),
          1'b0,32'd0,1'b0,32'd0);
    end
    // Full: fifth offer refused, also while a pop happens
    add(1'b0,1'b1,5'd9,32'h999,1'b0,5'd0,5'd0, 1'b0,1'b0,5'd1,32'h101,3'd4, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b1,5'd9,32'h999,1'b1,5'd0,5'd0, 1'b0,1'b1,5'd1,32'h101,3'd4, 1'b0,32'd0,1'b0,32'd0);
    for (int j = 2; j <= 4; j++) begin
      add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd0,5'd0,
          1'b1,1'b1,5'(j),32'h100 + 32'(j),3'(5 - j), 1'b0,32'd0,1'b0,32'd0);
    end
    add(1'b0,1'b0,5'd0,32'd0,1'b0,5'd9,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    // Youngest-match forwarding, independent ports
    add(1'b0,1'b1,5'd7,32'h11,1'b0,5'd7,5'd8, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b1,5'd7,32'h22,1'b0,5'd7,5'd8, 1'b1,1'b0,5'd7,32'h11,3'd1, 1'b1,32'h11,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b0,5'd7,5'd8, 1'b1,1'b0,5'd7,32'h11,3'd2, 1'b1,32'h22,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd7,5'd7, 1'b1,1'b1,5'd7,32'h11,3'd2, 1'b1,32'h22,1'b1,32'h22);
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd7,5'd0, 1'b1,1'b1,5'd7,32'h22,3'd1, 1'b1,32'h22,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b0,5'd7,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    // x0 writeback accepted but dropped
    add(1'b0,1'b1,5'd0,32'hDEAD,1'b1,5'd0,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd0,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    // Streaming push+pop at count=1 across pointer wrap
    for (int k = 1; k <= 10; k++) begin
      add(1'b0,1'b1,5'(k),32'h200 + 32'(k),1'b1,5'(k - 1),5'd0,
          1'b1,(k > 1),(k > 1) ? 5'(k - 1) : 5'd0,(k > 1) ? 32'h200 + 32'(k - 1) : 32'd0,
          (k > 1) ? 3'd1 : 3'd0,(k > 1),(k > 1) ? 32'h200 + 32'(k - 1) : 32'd0,1'b0,32'd0);
    end
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd10,5'd0, 1'b1,1'b1,5'd10,32'h20A,3'd1, 1'b1,32'h20A,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd10,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    // Push+pop at count=DEPTH-1
    add(1'b0,1'b1,5'd11,32'h311,1'b0,5'd0,5'd0, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b1,5'd12,32'h312,1'b0,5'd0,5'd0, 1'b1,1'b0,5'd11,32'h311,3'd1, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b1,5'd13,32'h313,1'b0,5'd0,5'd0, 1'b1,1'b0,5'd11,32'h311,3'd2, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b1,5'd14,32'h314,1'b1,5'd0,5'd0, 1'b1,1'b1,5'd11,32'h311,3'd3, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b0,5'd14,5'd11, 1'b1,1'b0,5'd12,32'h312,3'd3, 1'b1,32'h314,1'b0,32'd0);
    // Mid-operation reset with a handshake offered
    add(1'b1,1'b1,5'd20,32'h320,1'b0,5'd0,5'd0, 1'b0,1'b0,5'd12,32'h312,3'd3, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd13,5'd14, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
    add(1'b0,1'b0,5'd0,32'd0,1'b1,5'd12,5'd20, 1'b1,1'b0,5'd0,32'd0,3'd0, 1'b0,32'd0,1'b0,32'd0);
  endtask

  initial begin
    logic [4:0]  got_a[$];
    logic [31:0] got_d[$];
    int          got_c[$];
    int          n;

    rst = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    drain_en = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    build_table();
    @(negedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; wb_valid = vecs[i].v; wb_addr = vecs[i].a; wb_data = vecs[i].d;
      drain_en = vecs[i].dr; rd_addr1 = vecs[i].r1; rd_addr2 = vecs[i].r2;
      #1;
      check("wb_ready",  i, 32'(wb_ready),  32'(vecs[i].e_rdy));
      check("rf_we",     i, 32'(rf_we),     32'(vecs[i].e_we));
      check("rf_waddr",  i, 32'(rf_waddr),  32'(vecs[i].e_wa));
      check("rf_wdata",  i, rf_wdata,       vecs[i].e_wd);
      check("count",     i, 32'(count),     32'(vecs[i].e_cnt));
      check("fwd_hit1",  i, 32'(fwd_hit1),  32'(vecs[i].e_h1));
      check("fwd_data1", i, fwd_data1,      vecs[i].e_d1);
      check("fwd_hit2",  i, 32'(fwd_hit2),  32'(vecs[i].e_h2));
      check("fwd_data2", i, fwd_data2,      vecs[i].e_d2);
    end

    // Hand sequence: fill with drain off, then drain and record each write.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0; wb_valid = 1'b1; wb_addr = 5'(21 + i); wb_data = 32'h400 + 32'(21 + i);
      drain_en = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    end
    @(negedge clk);
    wb_valid = 1'b0; drain_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rf_we) begin
        got_a.push_back(rf_waddr);
        got_d.push_back(rf_wdata);
        got_c.push_back(c);
      end
      if (got_a.size() < 4) @(negedge clk);
      else break;
    end
    n = got_a.size();
    check("drain_count", 100, 32'(n), 32'd4);
    for (int i = 0; i < n && i < 4; i++) begin
      check("drain_addr", 100 + i, 32'(got_a[i]), 32'(21 + i));
      check("drain_data", 100 + i, got_d[i], 32'h400 + 32'(21 + i));
      check("drain_cycle", 100 + i, 32'(got_c[i]), 32'(got_c[0] + i));
    end
    @(negedge clk);
    drain_en = 1'b0;
    #1;
    check("drain_empty", 110, 32'(count), 32'd0);
    check("drain_we_off", 110, 32'(rf_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
